// File: rtl/acc8_frame_if.sv
// acc8_frame byte-stream / frame-total handshake bundle.
// master drives bytes and consumes totals; slave is the accumulator.
interface acc8_frame_if #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 16,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
);
    logic             i_valid;
    logic [7:0]       i_data;
    logic             o_ready;
    logic [ACC_W-1:0] o_sum;
    logic             o_sum_valid;
    logic             i_sum_ready;
    logic             o_ovf;
    logic [CNT_W-1:0] o_count;

    modport master (
        output i_valid, i_data, i_sum_ready,
        input  o_ready, o_sum, o_sum_valid, o_ovf, o_count
    );

    modport slave (
        input  i_valid, i_data, i_sum_ready,
        output o_ready, o_sum, o_sum_valid, o_ovf, o_count
    );
endinterface

// File: rtl/acc8_frame.sv
// Frame accumulator: sums FRAME_LEN bytes, low byte through adder8,
// presents the total with a handshake and a sticky overflow flag.
module adder8 (
    input  logic [7:0] i_A,
    input  logic [7:0] i_B,
    output logic [7:0] o_S,
    output logic       o_Cout
);
    // Plain 8-bit add with carry out
    assign {o_Cout, o_S} = {1'b0, i_A} + {1'b0, i_B};
endmodule

module acc8_frame #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 16,
    localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    acc8_frame_if.slave bus
);
    typedef enum logic {ACCUM, DONE} state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       s_lo;
    logic             c_lo;
    logic             c_top;

    adder8 u_add (
        .i_A    (acc_q[7:0]),
        .i_B    (bus.i_data),
        .o_S    (s_lo),
        .o_Cout (c_lo)
    );

    // Upper bits absorb the low-byte carry; with no upper bits the
    // adder carry is the frame overflow itself.
    if (ACC_W > 8) begin : g_hi
        logic [ACC_W-8:0] hi_w;
        assign hi_w  = {1'b0, acc_q[ACC_W-1:8]}
                     + {{(ACC_W-8){1'b0}}, c_lo};
        assign acc_d = {hi_w[ACC_W-9:0], s_lo};
        assign c_top = hi_w[ACC_W-8];
    end else begin : g_lo
        assign acc_d = s_lo;
        assign c_top = c_lo;
    end

    assign bus.o_ready     = (state_q == ACCUM);
    assign bus.o_sum_valid = (state_q == DONE);
    assign bus.o_sum       = acc_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_count     = cnt_q;

    // Frame FSM: accumulate until FRAME_LEN bytes, hold until released
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.i_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (c_top) ovf_q <= 1'b1;
                        if (cnt_q == CNT_W'(FRAME_LEN - 1))
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_sum_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_acc8_frame.sv
// Scoreboard bench for acc8_frame: 16-bit default instance plus an
// 8-bit instance for the overflow path.
module tb_acc8_frame;
    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    logic [16:0] q16[$];
    logic [8:0]  q8[$];

    always #5 clk = ~clk;

    acc8_frame_if #(.FRAME_LEN(4), .ACC_W(16)) b16 ();
    acc8_frame_if #(.FRAME_LEN(4), .ACC_W(8))  b8 ();

    acc8_frame #(.FRAME_LEN(4), .ACC_W(16)) dut16 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clr),
        .bus     (b16.slave)
    );

    acc8_frame #(.FRAME_LEN(4), .ACC_W(8)) dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clr),
        .bus     (b8.slave)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc16(input logic [7:0] d);
        chk("rdy16", 32'(b16.o_ready), 1);
        b16.i_valid = 1'b1;
        b16.i_data  = d;
        step();
        b16.i_valid = 1'b0;
    endtask

    task automatic acc8(input logic [7:0] d);
        chk("rdy8", 32'(b8.o_ready), 1);
        b8.i_valid = 1'b1;
        b8.i_data  = d;
        step();
        b8.i_valid = 1'b0;
    endtask

    task automatic rst_vals(input string n);
        chk({n, "_sum"}, 32'(b16.o_sum), 0);
        chk({n, "_cnt"}, 32'(b16.o_count), 0);
        chk({n, "_sv"}, 32'(b16.o_sum_valid), 0);
        chk({n, "_ovf"}, 32'(b16.o_ovf), 0);
        chk({n, "_rdy"}, 32'(b16.o_ready), 1);
    endtask

    // Monitor: each completed result handshake pops one expectation
    always @(negedge clk) begin
        if (b16.o_sum_valid && b16.i_sum_ready) begin
            logic [16:0] e;
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL sb16: unexpected total %0h", b16.o_sum);
            end else begin
                e = q16.pop_front();
                if ({b16.o_ovf, b16.o_sum} !== e) begin
                    errors++;
                    $display("FAIL sb16: got ovf=%0b sum=%0h want ovf=%0b sum=%0h",
                             b16.o_ovf, b16.o_sum, e[16], e[15:0]);
                end
            end
        end
        if (b8.o_sum_valid && b8.i_sum_ready) begin
            logic [8:0] e;
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL sb8: unexpected total %0h", b8.o_sum);
            end else begin
                e = q8.pop_front();
                if ({b8.o_ovf, b8.o_sum} !== e) begin
                    errors++;
                    $display("FAIL sb8: got ovf=%0b sum=%0h want ovf=%0b sum=%0h",
                             b8.o_ovf, b8.o_sum, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        b16.i_valid = 1'b0;
        b16.i_data = '0;
        b16.i_sum_ready = 1'b0;
        b8.i_valid = 1'b0;
        b8.i_data = '0;
        b8.i_sum_ready = 1'b0;
        step();
        step();
        rst_vals("reset");
        rst = 1'b0;
        step();

        // Carry chain
        q16.push_back({1'b0, 16'h0204});
        acc16(8'd7);
        acc16(8'd251);
        chk("cc_sum2", 32'(b16.o_sum), 32'h0102);
        chk("cc_cnt2", 32'(b16.o_count), 2);
        chk("cc_sv2", 32'(b16.o_sum_valid), 0);
        chk("cc_ovf2", 32'(b16.o_ovf), 0);
        acc16(8'd7);
        acc16(8'd251);
        chk("cc_sum4", 32'(b16.o_sum), 32'h0204);
        chk("cc_sv4", 32'(b16.o_sum_valid), 1);
        chk("cc_rdy4", 32'(b16.o_ready), 0);
        chk("cc_cnt4", 32'(b16.o_count), 4);
        b16.i_sum_ready = 1'b1;
        step();
        b16.i_sum_ready = 1'b0;
        chk("cc_rel_sum", 32'(b16.o_sum), 0);
        chk("cc_rel_rdy", 32'(b16.o_ready), 1);

        // Backpressure with bytes offered while DONE
        q16.push_back({1'b0, 16'h03FC});
        for (int i = 0; i < 4; i++) acc16(8'hFF);
        b16.i_valid = 1'b1;
        b16.i_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_sum", 32'(b16.o_sum), 32'h03FC);
            chk("bp_rdy", 32'(b16.o_ready), 0);
            chk("bp_cnt", 32'(b16.o_count), 4);
        end
        b16.i_sum_ready = 1'b1;
        step();
        b16.i_valid = 1'b0;
        b16.i_sum_ready = 1'b0;
        chk("bp_rel_sum", 32'(b16.o_sum), 0);
        chk("bp_rel_cnt", 32'(b16.o_count), 0);
        step();
        chk("bp_idle_sum", 32'(b16.o_sum), 0);

        // Clear mid-frame drops the same-cycle byte
        acc16(8'd10);
        acc16(8'd20);
        clr = 1'b1;
        b16.i_valid = 1'b1;
        b16.i_data  = 8'd99;
        step();
        clr = 1'b0;
        b16.i_valid = 1'b0;
        chk("clr_sum", 32'(b16.o_sum), 0);
        chk("clr_cnt", 32'(b16.o_count), 0);
        q16.push_back({1'b0, 16'd10});
        for (int i = 1; i <= 4; i++) acc16(8'(i));
        chk("clr_fr_sum", 32'(b16.o_sum), 10);
        chk("clr_fr_sv", 32'(b16.o_sum_valid), 1);
        b16.i_sum_ready = 1'b1;
        step();
        b16.i_sum_ready = 1'b0;

        // Reset mid-frame, then reset with a result pending
        acc16(8'd1);
        acc16(8'd2);
        acc16(8'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rst_vals("rst_mid");
        for (int i = 0; i < 4; i++) acc16(8'd5);
        chk("rst_done_sv", 32'(b16.o_sum_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rst_vals("rst_done");

        // Stalls: random gaps, total and timing unaffected
        q16.push_back({1'b0, 16'd10});
        for (int i = 1; i <= 4; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step();
                chk("st_sv_gap", 32'(b16.o_sum_valid), 0);
            end
            acc16(8'(i));
            if (i < 4) chk("st_sv_mid", 32'(b16.o_sum_valid), 0);
        end
        chk("st_sv", 32'(b16.o_sum_valid), 1);
        chk("st_sum", 32'(b16.o_sum), 10);
        b16.i_sum_ready = 1'b1;
        step();
        b16.i_sum_ready = 1'b0;

        // 8-bit overflow path
        q8.push_back({1'b1, 8'h02});
        acc8(8'h80);
        chk("ov_sum1", 32'(b8.o_sum), 32'h80);
        chk("ov_ovf1", 32'(b8.o_ovf), 0);
        acc8(8'h80);
        chk("ov_sum2", 32'(b8.o_sum), 0);
        chk("ov_ovf2", 32'(b8.o_ovf), 1);
        acc8(8'h01);
        acc8(8'h01);
        chk("ov_sum4", 32'(b8.o_sum), 2);
        chk("ov_ovf4", 32'(b8.o_ovf), 1);
        chk("ov_sv4", 32'(b8.o_sum_valid), 1);
        b8.i_sum_ready = 1'b1;
        step();
        b8.i_sum_ready = 1'b0;
        chk("ov_rel_ovf", 32'(b8.o_ovf), 0);
        chk("ov_rel_sum", 32'(b8.o_sum), 0);

        step();
        step();
        chk("sb16_left", 32'(q16.size()), 0);
        chk("sb8_left", 32'(q8.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
